// File: rtl/limit_control_mc.sv
// Multi-channel IEEE-754 limiter: clamps NCH values to per-channel bounds, one channel per clock.
// Optional LIMIT_SAT_FLAG_EN adds registered per-channel saturation flags; otherwise they read 0.
module limit_control_mc #(
  parameter int W   = 64,
  parameter int NCH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sta,
  input  logic [NCH*W-1:0] x,
  input  logic [NCH*W-1:0] upper_limit,
  input  logic [NCH*W-1:0] down_limit,
  output logic [NCH*W-1:0] y,
  output logic             busy,
  output logic             done_sig,
  output logic [NCH-1:0]   sat_hi,
  output logic [NCH-1:0]   sat_lo
);

  localparam int MW = (W == 32) ? 23 : 52;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             load, issue;
  logic [NCH*W-1:0] x_sh_reg, up_sh_reg, dn_sh_reg;

  logic             s1_valid_reg;
  logic [CW-1:0]    s1_ch_reg;
  logic             s1_gt_reg, s1_lt_reg;
  logic [W-1:0]     s1_x_reg;
  logic             done_reg;

  logic [W-1:0]     cur_x, cur_up, cur_dn;
  logic             gt_next, lt_next;
  logic [W-1:0]     sel_up, sel_dn, y_sel;

  // Monotone unsigned key for IEEE-754 ordering; -0 folds onto +0.
  function automatic logic [W-1:0] order_key(input logic [W-1:0] b);
    logic [W-1:0] v;
    v = (b[W-2:0] == '0) ? '0 : b;
    return v[W-1] ? ~v : {1'b1, v[W-2:0]};
  endfunction

  function automatic logic is_nan(input logic [W-1:0] b);
    return (&b[W-2:MW]) && (|b[MW-1:0]);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sta) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (cnt_reg == CW'(NCH - 1)) begin
          state_next = DRAIN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shadow copies let the producer change its outputs right after the start cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_sh_reg  <= '0;
      up_sh_reg <= '0;
      dn_sh_reg <= '0;
    end else if (load) begin
      x_sh_reg  <= x;
      up_sh_reg <= upper_limit;
      dn_sh_reg <= down_limit;
    end
  end

  always_comb begin
    cur_x   = x_sh_reg[cnt_reg*W +: W];
    cur_up  = up_sh_reg[cnt_reg*W +: W];
    cur_dn  = dn_sh_reg[cnt_reg*W +: W];
    gt_next = !is_nan(cur_x) && (order_key(cur_x) > order_key(cur_up));
    lt_next = !is_nan(cur_x) && (order_key(cur_x) < order_key(cur_dn));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_ch_reg    <= '0;
      s1_gt_reg    <= 1'b0;
      s1_lt_reg    <= 1'b0;
      s1_x_reg     <= '0;
      done_reg     <= 1'b0;
    end else begin
      s1_valid_reg <= issue;
      done_reg     <= (state_reg == DRAIN);
      if (issue) begin
        s1_ch_reg <= cnt_reg;
        s1_gt_reg <= gt_next;
        s1_lt_reg <= lt_next;
        s1_x_reg  <= cur_x;
      end
    end
  end

  // Limits stay stable in the shadows until the batch drains, so stage 2 reads them directly.
  always_comb begin
    sel_up = up_sh_reg[s1_ch_reg*W +: W];
    sel_dn = dn_sh_reg[s1_ch_reg*W +: W];
    if (s1_gt_reg)      y_sel = sel_up;
    else if (s1_lt_reg) y_sel = sel_dn;
    else                y_sel = s1_x_reg;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [W-1:0] y_ch_reg;
      logic         wr_ch;

      assign wr_ch = s1_valid_reg && (s1_ch_reg == CW'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) y_ch_reg <= '0;
        else if (wr_ch) y_ch_reg <= y_sel;
      end

      assign y[gi*W +: W] = y_ch_reg;

`ifdef LIMIT_SAT_FLAG_EN
      logic hi_reg, lo_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hi_reg <= 1'b0;
          lo_reg <= 1'b0;
        end else if (wr_ch) begin
          hi_reg <= s1_gt_reg;
          lo_reg <= !s1_gt_reg && s1_lt_reg;
        end
      end
      assign sat_hi[gi] = hi_reg;
      assign sat_lo[gi] = lo_reg;
`else
      assign sat_hi[gi] = 1'b0;
      assign sat_lo[gi] = 1'b0;
`endif
    end
  endgenerate

  assign busy     = (state_reg != IDLE);
  assign done_sig = done_reg;

endmodule

// File: tb/tb_limit_control_mc.sv
// Self-checking bench for limit_control_mc: 64-bit x4 instance with a real-valued reference model,
// plus a 32-bit single-channel instance for NaN pass-through and NCH=1 latency.
module tb_limit_control_mc;
  localparam int W   = 64;
  localparam int NCH = 4;
  localparam int NW  = NCH * W;
`ifdef LIMIT_SAT_FLAG_EN
  localparam bit FLAG_EN = 1'b1;
`else
  localparam bit FLAG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sta = 1'b0;
  logic [NW-1:0] x = '0, up = '0, dn = '0;
  logic [NW-1:0] y;
  logic busy, done_sig;
  logic [NCH-1:0] sat_hi, sat_lo;

  logic sta_s = 1'b0;
  logic [31:0] x_s = '0, up_s = '0, dn_s = '0;
  logic [31:0] y_s;
  logic busy_s, done_s;
  logic [0:0] hi_s, lo_s;

  int checks = 0;
  int errors = 0;

  logic [63:0] cx[NCH], cu[NCH], cd[NCH];
  logic [63:0] my[NCH], ny[NCH];
  logic        mhi[NCH], mlo[NCH], nhi[NCH], nlo[NCH];

  limit_control_mc #(.W(W), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .sta(sta), .x(x), .upper_limit(up), .down_limit(dn),
    .y(y), .busy(busy), .done_sig(done_sig), .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  limit_control_mc #(.W(32), .NCH(1)) dut_s (
    .clk(clk), .rst(rst), .sta(sta_s), .x(x_s), .upper_limit(up_s), .down_limit(dn_s),
    .y(y_s), .busy(busy_s), .done_sig(done_s), .sat_hi(hi_s), .sat_lo(lo_s)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rand_dbl();
    real r;
    r = (real'($urandom_range(0, 4000)) - 2000.0) / 16.0;
    return $realtobits(r);
  endfunction

  // Reference: ordinary real comparison (NaN compares false, -0 equals +0).
  task automatic model_batch();
    real xr, ur, dr;
    bit g, l;
    for (int i = 0; i < NCH; i++) begin
      xr = $bitstoreal(cx[i]);
      ur = $bitstoreal(cu[i]);
      dr = $bitstoreal(cd[i]);
      g = (xr > ur);
      l = (xr < dr);
      ny[i]  = g ? cu[i] : (l ? cd[i] : cx[i]);
      nhi[i] = g;
      nlo[i] = !g && l;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      x[i*W +: W]  = cx[i];
      up[i*W +: W] = cu[i];
      dn[i*W +: W] = cd[i];
    end
  endtask

  task automatic randomize_batch(input int inv_pct);
    logic [63:0] a, b;
    for (int i = 0; i < NCH; i++) begin
      a = rand_dbl();
      b = rand_dbl();
      if (($bitstoreal(a) > $bitstoreal(b)) == ($urandom_range(0, 99) >= inv_pct)) begin
        cu[i] = a; cd[i] = b;
      end else begin
        cu[i] = b; cd[i] = a;
      end
      cx[i] = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : rand_dbl();
    end
  endtask

  task automatic check_outputs(input string name, input int cyc);
    logic [63:0] ey;
    logic [1:0]  ef;
    for (int i = 0; i < NCH; i++) begin
      ey = (cyc >= 2 + i) ? ny[i] : my[i];
      ef = (cyc >= 2 + i) ? {nhi[i], nlo[i]} : {mhi[i], mlo[i]};
      if (!FLAG_EN) ef = 2'b00;
      checks++;
      if (y[i*W +: W] !== ey) begin
        errors++;
        $display("FAIL %s y[%0d] cyc %0d got %h expected %h", name, i, cyc, y[i*W +: W], ey);
      end
      checks++;
      if ({sat_hi[i], sat_lo[i]} !== ef) begin
        errors++;
        $display("FAIL %s flags[%0d] cyc %0d got %b expected %b", name, i, cyc, {sat_hi[i], sat_lo[i]}, ef);
      end
    end
  endtask

  task automatic run_batch(input string name, input bit hold, input bit chain);
    int lat;
    lat = 0;
    if (!chain) begin
      @(negedge clk);
      drive();
      sta = 1'b1;
    end
    model_batch();
    @(posedge clk);
    @(negedge clk);
    sta = hold;
    for (int k = 0; k < NW / 32; k++) begin
      x[k*32 +: 32]  = $urandom;
      up[k*32 +: 32] = $urandom;
      dn[k*32 +: 32] = $urandom;
    end
    checks++;
    if (busy !== 1'b1 || done_sig !== 1'b0) begin
      errors++;
      $display("FAIL %s start busy/done got %b%b expected 10", name, busy, done_sig);
    end
    for (int cyc = 1; cyc <= NCH + 6; cyc++) begin
      @(negedge clk);
      check_outputs(name, cyc);
      if (done_sig) begin
        lat = cyc;
        break;
      end
    end
    checks++;
    if (lat != NCH + 1) begin
      errors++;
      $display("FAIL %s latency got %0d expected %0d", name, lat, NCH + 1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy at done got %b expected 0", name, busy);
    end
    sta = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      my[i] = ny[i]; mhi[i] = nhi[i]; mlo[i] = nlo[i];
    end
    $display("batch %s latency %0d y %h", name, lat, y);
  endtask

  task automatic expect_quiet(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      checks++;
      if (done_sig !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s quiet cyc %0d busy/done got %b%b expected 00", name, c, busy, done_sig);
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NCH; i++) begin
      my[i] = '0; mhi[i] = 1'b0; mlo[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    clear_model();
    #2;
    checks++;
    if (y !== '0 || busy !== 1'b0 || done_sig !== 1'b0 || sat_hi !== '0 || sat_lo !== '0) begin
      errors++;
      $display("FAIL reset y=%h busy=%b done=%b hi=%b lo=%b expected all 0", y, busy, done_sig, sat_hi, sat_lo);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < NCH; i++) begin
      cx[i] = 64'h3FE0000000000000; cu[i] = 64'h4000000000000000; cd[i] = 64'hBFF0000000000000;
    end
    run_batch("passthrough", 1'b0, 1'b0);
    checks++;
    if (y !== {NCH{64'h3FE0000000000000}}) begin
      errors++;
      $display("FAIL passthrough_const got %h expected all 3FE0000000000000", y);
    end
  endtask

  task automatic test_clamp();
    cx[0] = 64'h4014000000000000; cx[1] = 64'hC008000000000000;
    cx[2] = 64'h3FF0000000000000; cx[3] = 64'h8000000000000000;
    run_batch("clamp", 1'b0, 1'b0);
    checks++;
    if (y !== {64'h8000000000000000, 64'h3FF0000000000000, 64'hBFF0000000000000, 64'h4000000000000000}) begin
      errors++;
      $display("FAIL clamp_const got %h", y);
    end
    checks++;
    if (sat_hi !== (FLAG_EN ? 4'b0001 : 4'b0000) || sat_lo !== (FLAG_EN ? 4'b0010 : 4'b0000)) begin
      errors++;
      $display("FAIL clamp_flags got hi %b lo %b", sat_hi, sat_lo);
    end
  endtask

  task automatic test_inverted();
    for (int i = 0; i < NCH; i++) begin
      cu[i] = 64'h3FF0000000000000; cd[i] = 64'h4008000000000000;
      cx[i] = i[0] ? 64'hC008000000000000 : 64'h4014000000000000;
    end
    run_batch("inverted", 1'b0, 1'b0);
    checks++;
    if (y[63:0] !== 64'h3FF0000000000000 || y[127:64] !== 64'h4008000000000000) begin
      errors++;
      $display("FAIL inverted_const got %h %h expected 3FF0000000000000 4008000000000000", y[63:0], y[127:64]);
    end
  endtask

  task automatic test_handshake();
    randomize_batch(10);
    run_batch("hold_sta", 1'b1, 1'b0);
    expect_quiet("hold_sta", 6);
    randomize_batch(10);
    run_batch("b2b_first", 1'b0, 1'b0);
    randomize_batch(10);
    drive();
    sta = 1'b1;
    run_batch("b2b_second", 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      randomize_batch(20);
      run_batch("random", 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    randomize_batch(10);
    @(negedge clk);
    drive();
    sta = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sta = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (y !== '0 || busy !== 1'b0 || sat_hi !== '0 || sat_lo !== '0 || done_sig !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid y=%h busy=%b done=%b hi=%b lo=%b expected all 0", y, busy, done_sig, sat_hi, sat_lo);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    $display("reset mid-batch applied");
    expect_quiet("reset_mid", 8);
    randomize_batch(10);
    run_batch("after_reset", 1'b0, 1'b0);
  endtask

  task automatic run32(input string name, input logic [31:0] xv, input logic [31:0] uv,
                       input logic [31:0] dv, input logic [31:0] ey, input logic eh);
    int lat;
    lat = 0;
    @(negedge clk);
    x_s = xv; up_s = uv; dn_s = dv; sta_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sta_s = 1'b0;
    x_s = $urandom; up_s = $urandom; dn_s = $urandom;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (done_s) begin
        lat = cyc;
        break;
      end
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL %s latency got %0d expected 2", name, lat);
    end
    checks++;
    if (y_s !== ey) begin
      errors++;
      $display("FAIL %s y got %h expected %h", name, y_s, ey);
    end
    checks++;
    if (hi_s !== (FLAG_EN & eh) || lo_s !== 1'b0) begin
      errors++;
      $display("FAIL %s flags got %b%b expected %b0", name, hi_s, lo_s, FLAG_EN & eh);
    end
    $display("w32 %s latency %0d y %h", name, lat, y_s);
  endtask

  task automatic test_w32_nan();
    run32("w32_nan", 32'h7FC00000, 32'h3F800000, 32'hBF800000, 32'h7FC00000, 1'b0);
    run32("w32_clamp", 32'h40A00000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 1'b1);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_clamp();
    test_inverted();
    test_handshake();
    test_random();
    test_reset_mid();
    test_w32_nan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/limit_control_mc.md
# limit_control_mc

Multi-channel, parametrised successor to the single-channel 64-bit limiter in the control-system library. It clamps NCH IEEE-754 values (single or double precision) each to its own upper and lower bound. A two-stage pipeline processes the channels sequentially, one channel per clock. The block is started with a `sta`/`done_sig` handshake and sits between a controller's computation stage and the plant-interface writeback. Comparison is done in-block with integer logic, so no vendor float IP is needed.

## Interface
- `W`, 64, float width: 32 or 64 only, IEEE-754 layout.
- `NCH`, 8, channel count, 1..64.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-high.
- `sta` in 1: start pulse; sampled only when idle.
- `x` in NCH*W: inputs; channel i is `x[i*W +: W]`.
- `upper_limit` in NCH*W: per-channel upper bound, same packing as `x`.
- `down_limit` in NCH*W: per-channel lower bound, same packing as `x`.
- `y` out NCH*W: clamped outputs, registered, same packing as `x`.
- `busy` out 1: high while a batch is in flight.
- `done_sig` out 1: one-cycle pulse when the batch completes.
- `sat_hi` out NCH: per-channel flag, 1 when the channel was clamped to its upper limit.
- `sat_lo` out NCH: per-channel flag, 1 when the channel was clamped to its lower limit.

## Operation
- FSM states:
  - IDLE: on `sta`, latch `x`, `upper_limit` and `down_limit` into shadow registers, clear the channel counter, go to RUN.
  - RUN: issue channel `cnt` to stage 1 each cycle. When `cnt == NCH-1` has been issued, go to DRAIN.
  - DRAIN: one cycle for stage 2 to write the last channel. Pulse `done_sig`, return to IDLE.
- Compare key: map each operand to an ordered unsigned integer.
  - Sign 0: key = `{1, bits[W-2:0]}`.
  - Sign 1: key = `~bits`.
  - -0 is normalised to +0 before mapping.
- Stage 1 registers three values: `gt = key(x) > key(up)`, `lt = key(x) < key(dn)`, and `x` itself.
- Stage 2 selection, in priority order:
  - `gt` → `y[ch] = up`.
  - else `lt` → `y[ch] = dn`.
  - else `y[ch] = x`.
- Inverted limits (`dn > up`): upper-limit priority applies. For example x=5.0, up=1.0, dn=3.0 gives y=1.0.
- NaN handling:
  - NaN in `x` (exponent all ones, mantissa ≠ 0) forces `gt = lt = 0`, so `x` passes through unchanged.
  - NaN limits are illegal input; resulting behaviour is undefined.
- Channels not yet processed in the current batch keep their previous `y` value.
- `sta` while `busy` is ignored. Inputs may change freely after the latch cycle.
- `rst` mid-batch: all state returns to reset values immediately. The partial batch is discarded and no `done_sig` is issued.

## Timing
- Reset values: `y` = 0, `sat_hi` = 0, `sat_lo` = 0, `busy` = 0, `done_sig` = 0, FSM in IDLE.
- Edge 0 samples `sta`: shadow registers load and `busy` rises.
- Channel i: stage 1 at edge 1+i, `y[i]` written at edge 2+i.
- `done_sig` is high for the cycle after edge NCH+1, coincident with the last `y` write. `busy` falls at the same edge.
- Batch latency is NCH+1 cycles from `sta` to `done_sig`. Throughput is one batch per NCH+2 cycles.
- A `sta` present during the `done_sig` cycle is accepted (back-to-back batches).
- NCH=1: `done_sig` at edge 2.

## Configuration
- `LIMIT_SAT_FLAG_EN` defined: `sat_hi[i]` / `sat_lo[i]` are registered alongside `y[i]`, set from stage-2 `gt` / `lt`.
  - Both flags are cleared per channel when that channel is written in range.
  - Flags hold between batches.
- Not defined: `sat_hi` and `sat_lo` are tied to 0 and the flag registers are not synthesised. All other behaviour is identical.

## Test plan
- **In-range pass-through.** W=64, NCH=4, all up=2.0 (4000000000000000), dn=-1.0 (BFF0000000000000), x=0.5 (3FE0000000000000) → all y=3FE0000000000000, `done_sig` at edge 5, flags 0.
- **Clamp both ways.** x={5.0, -3.0, 1.0, -0.0}, same limits → y={2.0, -1.0, 1.0, 0x8000000000000000}, `sat_hi`=0001b, `sat_lo`=0010b.
- **Inverted limits.** x=5.0, up=1.0, dn=3.0 → y=1.0 with `sat_hi` set. x=-3.0 → y=3.0 with `sat_lo` set.
- **Handshake.**
  - `sta` held high across a batch → exactly one batch, one `done_sig`.
  - `sta` during the `done_sig` cycle → second batch starts, next `done_sig` NCH+2 cycles later.
  - Inputs changed after edge 0 do not affect results.
- **Reset mid-batch.** Assert `rst` at edge 3 → `y`, flags and `busy` read 0 at once, no `done_sig`. The next `sta` runs normally.
- **W=32, NCH=1, NaN.** x=0x7FC00000 passes through unchanged. x=0x40A00000 (5.0), up=0x3F800000 (1.0) → y=0x3F800000, `done_sig` at edge 2.
